// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// Rev 1.0 - initial release.
`default_nettype none

module dcache_ctrl #(
  parameter int NUM_LINES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_ready,
  output logic          mem_write,
  output logic [31:0]   mem_read_address,
  output logic [31:0]   mem_write_address,
  output logic [127:0]  mem_write_data,
  input  logic [127:0]  mem_read_data,
  output logic [31:0]   stat_accesses,
  output logic [31:0]   stat_misses
);

  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 32 - IB - 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_FWAIT = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0]        tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];
  logic [31:2]          maddr_q;
  logic [31:0]          acc_q, miss_q;

  logic [1:0]    cpu_off;
  logic [IB-1:0] cpu_idx, m_idx;
  logic [TW-1:0] cpu_tag, m_tag;
  logic          hit, miss;

  assign cpu_off = cpu_addr[1:0];
  assign cpu_idx = cpu_addr[IB+1:2];
  assign cpu_tag = cpu_addr[31:IB+2];
  assign m_idx   = maddr_q[IB+1:2];
  assign m_tag   = maddr_q[31:IB+2];

  // Lookups only count in IDLE; the other states are busy servicing a miss.
  assign hit  = rst_n && (state_q == S_IDLE) && cpu_req && valid_q[cpu_idx] &&
                (tag_q[cpu_idx] == cpu_tag);
  assign miss = rst_n && (state_q == S_IDLE) && cpu_req && !hit;

  assign cpu_ready = hit;
  assign cpu_rdata = data_q[cpu_idx][32*cpu_off +: 32];

  assign mem_write         = rst_n && (state_q == S_WB);
  assign mem_read_address  = (state_q == S_IDLE) ? {cpu_addr[31:2], 2'b00}
                                                 : {maddr_q, 2'b00};
  assign mem_write_address = {tag_q[m_idx], m_idx, 2'b00};
  assign mem_write_data    = data_q[m_idx];

  assign stat_accesses = acc_q;
  assign stat_misses   = miss_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          state_d = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB:    state_d = S_FILL;
      S_FILL:  state_d = S_FWAIT;
      S_FWAIT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      acc_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      if (hit && cpu_we) begin
        dirty_q[cpu_idx] <= 1'b1;
      end
      if (state_q == S_FWAIT) begin
        valid_q[m_idx] <= 1'b1;
        dirty_q[m_idx] <= 1'b0;
      end
      if (cpu_req && cpu_ready && (acc_q != 32'hFFFF_FFFF)) begin
        acc_q <= acc_q + 32'd1;
      end
      if (miss && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  // Line contents and miss address need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (miss) begin
      maddr_q <= cpu_addr[31:2];
    end
    if (hit && cpu_we) begin
      data_q[cpu_idx][32*cpu_off +: 32] <= cpu_wdata;
    end
    if (rst_n && (state_q == S_FWAIT)) begin
      data_q[m_idx] <= mem_read_data;
      tag_q[m_idx]  <= m_tag;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a behavioural data_memory.
// Rev 1.0 - initial release.
`default_nettype none

module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         mem_write;
  logic [31:0]  mem_read_address;
  logic [31:0]  mem_write_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data = '0;
  logic [31:0]  stat_accesses;
  logic [31:0]  stat_misses;

  int checks = 0;
  int errors = 0;

  logic         wr_seen;
  logic [31:0]  wr_addr;
  logic [127:0] wr_line;
  logic         fill_got;
  logic [31:0]  fill_addr;

  logic [31:0] mem [int unsigned];

  dcache_ctrl #(.NUM_LINES(64)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_ready         (cpu_ready),
    .mem_write         (mem_write),
    .mem_read_address  (mem_read_address),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_data     (mem_read_data),
    .stat_accesses     (stat_accesses),
    .stat_misses       (stat_misses)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Registered-read, edge-write data_memory.
  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) begin
        mem[mem_write_address + k] = mem_write_data[32*k +: 32];
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        mem_read_data[32*k +: 32] <= rd_word(mem_read_address + k);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, act, exp);
    end
  endtask

  task automatic observe(input int n);
    if (mem_write) begin
      wr_seen = 1'b1;
      wr_addr = mem_write_address;
      wr_line = mem_write_data;
    end else if (n > 0 && !fill_got) begin
      fill_got  = 1'b1;
      fill_addr = mem_read_address;
    end
  endtask

  // Issue one access and hold it until cpu_ready; n counts cycles after the request cycle.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_n, input logic [31:0] exp_rd, input string name);
    int n;
    n = 0;
    wr_seen = 1'b0;
    fill_got = 1'b0;
    fill_addr = 32'h0;
    wr_addr = 32'h0;
    wr_line = '0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    @(negedge clk);
    observe(n);
    while (!cpu_ready && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      observe(n);
    end
    chk({name, "_latency"}, n, exp_n);
    if (!we) chk({name, "_rdata"}, cpu_rdata, exp_rd);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_memwr", {31'd0, mem_write}, 32'd0);
    chk("rst_acc", stat_accesses, 32'd0);
    chk("rst_miss", stat_misses, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold load miss, clean fill.
    access(1'b0, 32'h40, 32'h0, 3, 32'hA5A5_0040, "ld40");
    chk("ld40_fill_addr", fill_addr, 32'h40);
    chk("ld40_no_wb", {31'd0, wr_seen}, 32'd0);
    chk("ld40_miss", stat_misses, 32'd1);
    chk("ld40_acc", stat_accesses, 32'd1);

    access(1'b0, 32'h41, 32'h0, 0, 32'hA5A5_0041, "ld41");
    chk("ld41_no_wr", {31'd0, wr_seen}, 32'd0);

    // Store hit dirties line 16, then a conflicting load writes it back.
    access(1'b1, 32'h42, 32'hDEAD_BEEF, 0, 32'h0, "st42");
    access(1'b0, 32'h142, 32'h0, 4, 32'hA5A5_0142, "ld142");
    chk("ld142_wb", {31'd0, wr_seen}, 32'd1);
    chk("ld142_wb_addr", wr_addr, 32'h40);
    chk("ld142_wb_w2", wr_line[95:64], 32'hDEAD_BEEF);
    chk("ld142_wb_w0", wr_line[31:0], 32'hA5A5_0040);
    chk("ld142_fill_addr", fill_addr, 32'h140);

    access(1'b0, 32'h242, 32'h0, 3, 32'hA5A5_0242, "ld242");
    chk("ld242_no_wb", {31'd0, wr_seen}, 32'd0);

    // Written-back store data must come back from memory.
    access(1'b0, 32'h42, 32'h0, 3, 32'hDEAD_BEEF, "ld42");

    // Store miss allocates, then a conflict writes the stored word back.
    access(1'b1, 32'h300, 32'h0000_1234, 3, 32'h0, "st300");
    access(1'b0, 32'h300, 32'h0, 0, 32'h0000_1234, "ld300");
    access(1'b0, 32'h400, 32'h0, 4, 32'hA5A5_0400, "ld400");
    chk("ld400_wb_addr", wr_addr, 32'h300);
    chk("ld400_wb_w0", wr_line[31:0], 32'h0000_1234);
    chk("stat_miss6", stat_misses, 32'd6);
    chk("stat_acc9", stat_accesses, 32'd9);

    // Top-of-memory line.
    access(1'b0, 32'hFFFF_FFFF, 32'h0, 3, 32'h5A5A_FFFF, "ldtop");
    chk("ldtop_fill_addr", fill_addr, 32'hFFFF_FFFC);

    // Reset asserted during FWAIT.
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 32'h500;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rstfw_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rstfw_memwr", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstfw_acc", stat_accesses, 32'd0);
    chk("rstfw_miss", stat_misses, 32'd0);
    @(negedge clk);
    chk("rstfw_idle_memwr", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    access(1'b0, 32'h41, 32'h0, 3, 32'hA5A5_0041, "reld41");
    chk("reld41_miss", stat_misses, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
